// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: reads a word-aligned message, builds padded 512-bit blocks and
// chains them through the compression core. Digest write-back: SHA256_FEEDER_WRITEBACK_EN.
module sha256_msg_feeder #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     msg_addr,
  input  logic [LEN_W-1:0]      msg_words,
  input  logic [ADDR_W-1:0]     out_addr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic                  blk_start,
  output logic [511:0]          blk_data,
  output logic [7:0][31:0]      blk_h_init,
  output logic [7:0][31:0]      blk_alpha_init,
  input  logic                  blk_done,
  input  logic [7:0][31:0]      blk_hash,
  output logic [7:0][31:0]      digest,
  output logic                  done,
  output logic                  busy
);

  localparam logic [7:0][31:0] SHA_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LAUNCH,
    S_WAIT_LO,
    S_WAIT_HI,
    S_FINISH,
`ifdef SHA256_FEEDER_WRITEBACK_EN
    S_WB,
`endif
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   base_addr;
  logic [LEN_W-1:0]    n_words;
  logic [LEN_W-1:0]    blk_idx;
  logic [4:0]          cnt;
  logic                pend_valid;
  logic [3:0]          pend_j;
  logic [15:0][31:0]   blk_words;
  logic [7:0][31:0]    h_reg;

  // Global slot index g = 16*b + j, and the slot classification derived from it.
  logic [LEN_W+3:0]    g_idx;
  logic [LEN_W:0]      last_blk;
  logic                is_last;
  logic                slot_mem;
  logic                slot_pad;
  logic [31:0]         slot_val;

  assign g_idx    = {blk_idx, cnt[3:0]};
  assign last_blk = ({1'b0, n_words} + (LEN_W+1)'(2)) >> 4;
  assign is_last  = ({1'b0, blk_idx} == last_blk);
  assign slot_mem = g_idx < (LEN_W+4)'(n_words);
  assign slot_pad = g_idx == (LEN_W+4)'(n_words);

  // NOTE: every variable driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    slot_val = 32'h0;
    if (slot_pad)
      slot_val = 32'h8000_0000;
    else if (is_last && cnt[3:0] == 4'd15)
      slot_val = 32'({n_words, 5'b0});
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start) state_n = S_FILL;
      S_FILL:    if (cnt == 5'd16) state_n = S_LAUNCH;
      S_LAUNCH:  state_n = S_WAIT_LO;
      // The core still shows idle during the launch cycle; completion only counts after it drops.
      S_WAIT_LO: if (!blk_done) state_n = S_WAIT_HI;
      S_WAIT_HI: if (blk_done) state_n = is_last ? S_FINISH : S_FILL;
`ifdef SHA256_FEEDER_WRITEBACK_EN
      S_FINISH:  state_n = S_WB;
      S_WB:      if (cnt == 5'd7) state_n = S_DONE;
`else
      S_FINISH:  state_n = S_DONE;
`endif
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

`ifdef SHA256_FEEDER_WRITEBACK_EN
  logic [ADDR_W-1:0] wb_addr;

  always_ff @(posedge clk) begin
    if (reset)                        wb_addr <= '0;
    else if (state == S_IDLE && start) wb_addr <= out_addr;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_addr  <= '0;
      n_words    <= '0;
      blk_idx    <= '0;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_j     <= '0;
      blk_words  <= '0;
      h_reg      <= SHA_IV;
      digest     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_addr  <= msg_addr;
            n_words    <= msg_words;
            blk_idx    <= '0;
            cnt        <= '0;
            pend_valid <= 1'b0;
            h_reg      <= SHA_IV;
          end
        end
        S_FILL: begin
          // The word requested in the previous cycle lands now.
          if (pend_valid)
            blk_words[pend_j] <= mem_read_data;
          if (!cnt[4]) begin
            pend_valid <= slot_mem;
            pend_j     <= cnt[3:0];
            if (!slot_mem)
              blk_words[cnt[3:0]] <= slot_val;
            cnt <= cnt + 5'd1;
          end else begin
            pend_valid <= 1'b0;
            cnt        <= '0;
          end
        end
        S_WAIT_HI: begin
          if (blk_done) begin
            h_reg   <= blk_hash;
            blk_idx <= blk_idx + 1'b1;
            cnt     <= '0;
          end
        end
        S_FINISH: begin
          digest <= h_reg;
          cnt    <= '0;
        end
`ifdef SHA256_FEEDER_WRITEBACK_EN
        S_WB: cnt <= cnt + 5'd1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    if (state == S_FILL && !cnt[4] && slot_mem)
      mem_addr = base_addr + ADDR_W'(g_idx);
`ifdef SHA256_FEEDER_WRITEBACK_EN
    if (state == S_WB)
      mem_addr = wb_addr + ADDR_W'(cnt[2:0]);
`endif
  end

`ifdef SHA256_FEEDER_WRITEBACK_EN
  // Reset is combined in so a write cannot complete on the edge that aborts the operation.
  assign mem_we         = (state == S_WB) && !reset;
  assign mem_write_data = (state == S_WB) ? digest[cnt[2:0]] : 32'h0;
`else
  logic unused_out_addr;
  assign unused_out_addr = ^out_addr;
  assign mem_we          = 1'b0;
  assign mem_write_data  = 32'h0;
`endif

  assign blk_start      = (state == S_LAUNCH) && !reset;
  assign blk_data       = blk_words;
  assign blk_h_init     = h_reg;
  assign blk_alpha_init = h_reg;
  assign done           = (state == S_DONE);
  assign busy           = (state != S_IDLE) && (state != S_DONE);

endmodule
